// File: rtl/iic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iic_pkg : shared types and constants for the I2C sequence master           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_ACK    = 3'd4,
    ST_STOP   = 3'd5,
    ST_GAP    = 3'd6,
    ST_FINISH = 3'd7
  } state_t;

  localparam logic [1:0] PH_Q0 = 2'd0;
  localparam logic [1:0] PH_Q1 = 2'd1;
  localparam logic [1:0] PH_Q2 = 2'd2;
  localparam logic [1:0] PH_Q3 = 2'd3;

  // Bytes per write: device address, register address bytes, data.
  function automatic int byte_count(input int reg_bytes);
    return reg_bytes + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iic_qtr_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iic_qtr_tick : quarter-period tick divider with hold (count frozen at 0)   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module iic_qtr_tick #(
  parameter int QTR_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !hold && (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/iic_seq_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iic_seq_master : table-driven I2C write engine with stretch and NACK retry |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module iic_seq_master
  import iic_pkg::*;
#(
  parameter int         QTR_DIV   = 20,
  parameter int         REG_BYTES = 2,
  parameter int         TBL_AW    = 6,
  parameter int         MAX_RETRY = 3,
  parameter logic [6:0] DEV_ADDR  = 7'h3C
) (
  input  logic                     clk_8m,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TBL_AW:0]          tbl_len,
  output logic [TBL_AW-1:0]        tbl_addr,
  input  logic [8*REG_BYTES+7:0]   tbl_data,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     scl_oe,
  output logic                     sda_oe,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [TBL_AW-1:0]        err_idx
);

  localparam int NBYTES = byte_count(REG_BYTES);
  localparam int DW     = 8*REG_BYTES + 8;
  localparam int SW     = 8*NBYTES;
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW     = $clog2(NBYTES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  state_t          state, state_d;
  logic            start_q, accept, tick, hold, stretch, bus_end;
  logic            fetch_wait, q3_first, ack_bit, retry_pend, sda_drive;
  logic [TBL_AW:0] index, index_nxt;
  logic [DW-1:0]   entry;
  logic [SW-1:0]   shreg;
  logic [1:0]      phase;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [RW-1:0]   retry_cnt;

  assign accept    = start && !start_q && (state == ST_IDLE);
  assign bus_end   = tick && (phase == PH_Q3);
  assign index_nxt = index + (TBL_AW+1)'(1);
  assign tbl_addr  = index[TBL_AW-1:0];
  assign busy      = (state != ST_IDLE) && (state != ST_FINISH);
  assign done      = (state == ST_FINISH);

  // Slave may hold SCL low after we release it; freeze the quarter timer until it lets go.
  assign stretch = !scl_in &&
                   ((((state == ST_SHIFT) || (state == ST_ACK)) && (phase == PH_Q2)) ||
                    ((state == ST_STOP) && (phase == PH_Q1)));
  assign hold = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_FINISH) || stretch;

  iic_qtr_tick #(
    .QTR_DIV (QTR_DIV)
  ) u_qtr_tick (
    .clk  (clk_8m),
    .rst  (rst),
    .hold (hold),
    .tick (tick)
  );

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    scl_oe    = 1'b0;
    sda_drive = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = (tbl_len == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_wait) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        scl_oe    = (phase == PH_Q3);
        sda_drive = (phase != PH_Q0);
        if (bus_end) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scl_oe    = !phase[1];
        sda_drive = !shreg[SW-1];
        if (bus_end && (bit_cnt == 3'd7)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        scl_oe = !phase[1];
        if (bus_end) begin
          state_d = (ack_bit || (byte_cnt == LAST_BYTE)) ? ST_STOP : ST_SHIFT;
        end
      end
      ST_STOP: begin
        scl_oe    = (phase == PH_Q0);
        sda_drive = (phase != PH_Q3);
        if (bus_end) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (bus_end) begin
          if (retry_pend) begin
            state_d = (retry_cnt < RETRY_MAX) ? ST_START : ST_FINISH;
          end else if (index_nxt == tbl_len) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // SDA is registered so it always moves one clock after the SCL falling edge.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      start_q    <= 1'b0;
      sda_oe     <= 1'b0;
      phase      <= PH_Q0;
      fetch_wait <= 1'b0;
      q3_first   <= 1'b0;
      ack_bit    <= 1'b0;
      retry_pend <= 1'b0;
      retry_cnt  <= '0;
      index      <= '0;
      entry      <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      err        <= 1'b0;
      err_idx    <= '0;
    end else begin
      start_q    <= start;
      sda_oe     <= sda_drive;
      q3_first   <= tick && (phase == PH_Q2);
      fetch_wait <= (state == ST_FETCH) && !fetch_wait;
      if (state == ST_IDLE) begin
        phase <= PH_Q0;
      end else if (tick) begin
        phase <= phase + 2'd1;
      end
      if ((state == ST_FETCH) && fetch_wait) begin
        entry <= tbl_data;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            index      <= '0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            err        <= 1'b0;
          end
        end
        ST_START: begin
          shreg    <= {DEV_ADDR, 1'b0, entry};
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        ST_SHIFT: begin
          if (bus_end) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_ACK: begin
          if (q3_first) begin
            ack_bit <= sda_in;
          end
          if (bus_end) begin
            byte_cnt <= byte_cnt + BW'(1);
            if (ack_bit) begin
              retry_pend <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (bus_end) begin
            retry_pend <= 1'b0;
            if (retry_pend) begin
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt <= retry_cnt + RW'(1);
              end else begin
                err     <= 1'b1;
                err_idx <= index[TBL_AW-1:0];
              end
            end else begin
              retry_cnt <= '0;
              index     <= index_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iic_seq_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iic_seq_master : bus-level scoreboard bench with an I2C slave model     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_iic_seq_master;

  localparam int QTR = 8;
  localparam int AW  = 6;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 257;

  logic          clk_8m = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   tbl_len = '0;
  logic [AW-1:0] tbl_addr;
  logic [23:0]   tbl_data;
  logic          scl_in, sda_in, scl_oe, sda_oe, busy, done, err;
  logic [AW-1:0] err_idx;
  logic [23:0]   rom [0:63];

  logic sda_ack = 1'b0;
  logic armed   = 1'b0;

  always #5 clk_8m = ~clk_8m;

  assign scl_in = ~(scl_oe | armed);
  assign sda_in = ~(sda_oe | sda_ack);

  always @(posedge clk_8m) tbl_data <= rom[tbl_addr];

  iic_seq_master #(
    .QTR_DIV(QTR), .REG_BYTES(2), .TBL_AW(AW), .MAX_RETRY(3), .DEV_ADDR(7'h3C)
  ) dut (
    .clk_8m(clk_8m), .rst(rst), .start(start), .tbl_len(tbl_len), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  int n_vec = 0, n_err = 0;
  int exp_q[$];
  bit sb_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic emit(input int code);
    if (sb_en) begin
      if (exp_q.size() == 0) check("bus_event_unexpected", code, -1);
      else check("bus_event", code, exp_q.pop_front());
    end
  endtask

  // Slave model and bus monitor
  int nack_lo = 1, nack_hi = 0;
  bit stretch_en = 1'b0, stretch_used = 1'b0, was_stretched = 1'b0;
  int txn_cnt = 0, cur_txn = 0, bit_n = 0, byte_n = 0;
  int high_cnt = 0, low_cnt = 0, hold_cnt = 0;
  logic [7:0] sh = '0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;

  always @(negedge clk_8m) begin
    if (rst) begin
      prev_scl = 1'b1; prev_sda = 1'b1; bit_n = 0; sda_ack = 1'b0; armed = 1'b0;
    end else begin
      cur_scl = scl_in;
      cur_sda = sda_in;
      if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        emit(EV_START);
        cur_txn = txn_cnt; txn_cnt++; bit_n = 0; byte_n = 0;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        emit(EV_STOP);
        bit_n = 0; sda_ack = 1'b0;
      end else if (!prev_scl && cur_scl) begin
        high_cnt = 0;
        if (bit_n < 8) begin
          sh = {sh[6:0], cur_sda};
          bit_n++;
        end
      end else if (prev_scl && !cur_scl) begin
        if (bit_n == 8) begin
          emit(int'(sh));
          sda_ack = !(byte_n == 0 && cur_txn >= nack_lo && cur_txn <= nack_hi);
          if (stretch_en && !stretch_used && byte_n == 2) begin
            armed = 1'b1; stretch_used = 1'b1; was_stretched = 1'b1; hold_cnt = 0;
          end
          low_cnt = 0;
          bit_n = 9;
        end else if (bit_n == 9) begin
          sda_ack = 1'b0;
          if (was_stretched) begin
            check_rng("stretch_high_time", high_cnt, 2*QTR-1, 2*QTR);
            check_rng("stretch_low_time", low_cnt, 500, 540);
            was_stretched = 1'b0;
          end
          bit_n = 0;
          byte_n++;
        end
      end
      if (cur_scl) high_cnt++; else low_cnt++;
      // Hold SCL from the moment the master releases it, for 500 cycles.
      if (armed && !scl_oe) begin
        hold_cnt++;
        if (hold_cnt >= 500) armed = 1'b0;
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  int done_cnt = 0, busy_cnt = 0;
  int addr_log[$];
  logic prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk_8m) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (busy && (!prev_busy || tbl_addr != prev_addr)) addr_log.push_back(int'(tbl_addr));
    prev_busy = busy;
    prev_addr = tbl_addr;
  end

  task automatic push_txn(input logic [23:0] e, input bit nack);
    exp_q.push_back(EV_START);
    exp_q.push_back(8'h78);
    if (!nack) begin
      exp_q.push_back(int'(e[23:16]));
      exp_q.push_back(int'(e[15:8]));
      exp_q.push_back(int'(e[7:0]));
    end
    exp_q.push_back(EV_STOP);
  endtask

  task automatic pulse_start();
    @(negedge clk_8m); start = 1'b1;
    @(negedge clk_8m); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clk_8m);
      t++;
    end
    check("done_within_budget", int'(done === 1'b1), 1);
    repeat (3) @(negedge clk_8m);
  endtask

  int d0, b0, a0, lat;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 24'(i * 24'h010101);

    // Reset state
    repeat (3) @(negedge clk_8m);
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_idx", int'(err_idx), 0);
    check("rst_tbl_addr", int'(tbl_addr), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk_8m);

    // Single entry, plus a start edge while busy that must be ignored
    rom[0] = 24'h300882;
    push_txn(24'h300882, 1'b0);
    d0 = done_cnt; b0 = busy_cnt;
    tbl_len = 7'd1;
    pulse_start();
    repeat (300) @(negedge clk_8m);
    pulse_start();
    wait_done(3000);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_err", int'(err), 0);
    check_rng("t1_busy_cycles", busy_cnt - b0, 152*QTR, 156*QTR + 8);
    check("t1_drained", exp_q.size(), 0);

    // Three entries, all acknowledged
    rom[0] = 24'h123456; rom[1] = 24'hABCDEF; rom[2] = 24'h0F00A5;
    push_txn(rom[0], 1'b0); push_txn(rom[1], 1'b0); push_txn(rom[2], 1'b0);
    d0 = done_cnt; a0 = addr_log.size();
    tbl_len = 7'd3;
    pulse_start();
    wait_done(6000);
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_addr_count", addr_log.size() - a0, 3);
    if (addr_log.size() - a0 == 3) begin
      check("t2_addr0", addr_log[a0], 0);
      check("t2_addr1", addr_log[a0+1], 1);
      check("t2_addr2", addr_log[a0+2], 2);
    end
    check("t2_err", int'(err), 0);
    check("t2_drained", exp_q.size(), 0);

    // Entry 1 NACKed twice on the address byte, then accepted
    push_txn(rom[0], 1'b0);
    push_txn(rom[1], 1'b1); push_txn(rom[1], 1'b1); push_txn(rom[1], 1'b0);
    push_txn(rom[2], 1'b0);
    nack_lo = txn_cnt + 1; nack_hi = txn_cnt + 2;
    d0 = done_cnt; a0 = addr_log.size();
    pulse_start();
    wait_done(9000);
    check("t3_done_pulses", done_cnt - d0, 1);
    check("t3_err", int'(err), 0);
    check("t3_fetches", addr_log.size() - a0, 3);
    check("t3_drained", exp_q.size(), 0);

    // Persistent NACK on entry 2: four attempts, then error with index 2
    rom[3] = 24'h777777; rom[4] = 24'h888888;
    push_txn(rom[0], 1'b0); push_txn(rom[1], 1'b0);
    for (int k = 0; k < 4; k++) push_txn(rom[2], 1'b1);
    nack_lo = txn_cnt + 2; nack_hi = txn_cnt + 5;
    d0 = done_cnt; a0 = addr_log.size();
    tbl_len = 7'd5;
    pulse_start();
    wait_done(12000);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_err", int'(err), 1);
    check("t4_err_idx", int'(err_idx), 2);
    check("t4_fetches", addr_log.size() - a0, 3);
    check("t4_last_addr", addr_log[addr_log.size()-1], 2);
    check("t4_drained", exp_q.size(), 0);
    nack_lo = 1; nack_hi = 0;

    // Clock stretch in the ACK bit of byte 2
    rom[0] = 24'h5AC33C;
    push_txn(rom[0], 1'b0);
    stretch_en = 1'b1;
    d0 = done_cnt;
    tbl_len = 7'd1;
    pulse_start();
    wait_done(3000);
    stretch_en = 1'b0;
    check("t5_stretch_applied", int'(stretch_used), 1);
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_err_cleared", int'(err), 0);
    check("t5_drained", exp_q.size(), 0);

    // Empty table: done almost immediately, no bus activity
    tbl_len = '0;
    d0 = done_cnt;
    @(negedge clk_8m); start = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk_8m);
      start = 1'b0;
      lat++;
    end
    start = 1'b0;
    check_rng("t6_done_latency", lat, 1, 2);
    repeat (20) @(negedge clk_8m);
    check("t6_done_pulses", done_cnt - d0, 1);
    check("t6_no_bus", exp_q.size(), 0);

    // Reset asserted mid-byte
    sb_en = 1'b0;
    tbl_len = 7'd1;
    pulse_start();
    repeat (400) @(negedge clk_8m);
    check("t7_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk_8m); #1;
    check("t7_scl_oe", int'(scl_oe), 0);
    check("t7_sda_oe", int'(sda_oe), 0);
    check("t7_busy", int'(busy), 0);
    @(negedge clk_8m); rst = 1'b0;
    repeat (10) @(negedge clk_8m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
